// File: rtl/lane_cpu_pkg.sv
// Shared constants and types for the lane-wise SIMD CPU: memory sizes,
// load-stream marker bytes, ISA opcode/funct3 encodings, FSM and ALU enums.
package lane_cpu_pkg;

    localparam int IMEM_WORDS = 64;
    localparam int DMEM_WORDS = 32;
    localparam int NREGS      = 32;

    // Stream control bytes: 0xFE opens a load, 0xFF at byte index 0 ends it.
    localparam logic [7:0] LOAD_MARKER = 8'hFE;
    localparam logic [7:0] END_MARKER  = 8'hFF;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SLT = 3'd2;
    localparam logic [2:0] F3_XOR = 3'd4;
    localparam logic [2:0] F3_OR  = 3'd6;
    localparam logic [2:0] F3_AND = 3'd7;
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_BNE = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

endpackage

// File: rtl/lane_alu.sv
// Combinational lane-wise ALU: four independent signed 8-bit lanes,
// wrap-around arithmetic, no carries crossing lane boundaries.
module lane_alu
    import lane_cpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  op_i,
    output logic [31:0] y_o
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic signed [7:0] a_l;
        logic signed [7:0] b_l;
        logic        [7:0] r_l;

        assign a_l = a_i[8*l +: 8];
        assign b_l = b_i[8*l +: 8];

        // Per-lane operation; SLT yields 0x01/0x00 from a signed compare
        always_comb begin
            r_l = 8'h00;
            case (op_i)
                ALU_ADD: r_l = a_l + b_l;
                ALU_SUB: r_l = a_l - b_l;
                ALU_XOR: r_l = a_l ^ b_l;
                ALU_OR:  r_l = a_l | b_l;
                ALU_AND: r_l = a_l & b_l;
                ALU_SLT: r_l = (a_l < b_l) ? 8'h01 : 8'h00;
                default: r_l = 8'h00;
            endcase
        end

        assign y_o[8*l +: 8] = r_l;
    end

endmodule

// File: rtl/lane_simd_cpu.sv
// Lane-wise SIMD CPU: byte-serial program load into imem, one instruction
// per cycle execution, combinational debug read of registers / data memory.
module lane_simd_cpu
    import lane_cpu_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset,
    input  logic [7:0] instr_i,
    input  logic       DataOrReg,
    input  logic [4:0] address,
    input  logic [1:0] vout_addr,
    output logic [7:0] value_o,
    output logic       is_positive,
    output logic [2:0] easter_egg
);

    state_e      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [6:0]  count_q, count_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] word_buf_q, word_buf_d;
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];
    logic [31:0] dmem_q [DMEM_WORDS];
    logic [31:0] dmem_d [DMEM_WORDS];
    logic [31:0] imem_q [IMEM_WORDS];

    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;

    // Instruction fields
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [7:0]  imm_i8;
    logic [4:0]  imm_s5;
    logic [5:0]  br_off;
    logic        unused_instr;

    assign instr        = imem_q[pc_q];
    assign opcode       = instr[6:0];
    assign rd           = instr[11:7];
    assign funct3       = instr[14:12];
    assign rs1          = instr[19:15];
    assign rs2          = instr[24:20];
    assign rs1_val      = regs_q[rs1];
    assign rs2_val      = regs_q[rs2];
    assign imm_i8       = instr[27:20];
    assign imm_s5       = instr[11:7];
    // Branch byte offset bits [7:2]: word offset, modulo the 64-word PC space
    assign br_off       = {instr[27:25], instr[11:9]};
    assign unused_instr = ^instr[31:28];

    // Decode controls
    logic        valid;
    logic        wb_alu, wb_load, do_store, do_branch;
    logic [2:0]  alu_op;
    logic [31:0] alu_b, alu_y;
    logic [4:0]  mem_addr;
    logic        br_taken;
    logic        at_end;

    assign mem_addr = rs1_val[4:0] + (do_store ? imm_s5 : imm_i8[4:0]);
    assign br_taken = (funct3 == F3_BEQ) ? (rs1_val == rs2_val) : (rs1_val != rs2_val);
    assign at_end   = ({1'b0, pc_q} == count_q);

    lane_alu u_alu (
        .a_i  (rs1_val),
        .b_i  (alu_b),
        .op_i (alu_op),
        .y_o  (alu_y)
    );

    // Instruction decode; unknown opcodes or funct3 values mark the word invalid
    always_comb begin
        valid     = 1'b1;
        wb_alu    = 1'b0;
        wb_load   = 1'b0;
        do_store  = 1'b0;
        do_branch = 1'b0;
        alu_op    = ALU_ADD;
        alu_b     = rs2_val;
        case (opcode)
            OP_R: begin
                wb_alu = 1'b1;
                case (funct3)
                    F3_ADD:  alu_op = instr[30] ? ALU_SUB : ALU_ADD;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    default: valid  = 1'b0;
                endcase
            end
            OP_I: begin
                wb_alu = 1'b1;
                alu_b  = {4{imm_i8}};
                case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    default: valid  = 1'b0;
                endcase
            end
            OP_LW: wb_load  = 1'b1;
            OP_SW: do_store = 1'b1;
            OP_BR: begin
                do_branch = 1'b1;
                if (funct3 != F3_BEQ && funct3 != F3_BNE) valid = 1'b0;
            end
            default: valid = 1'b0;
        endcase
    end

    // State register plus all architectural flops, cleared asynchronously
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            regs_q     <= '{default: '0};
            dmem_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            regs_q     <= regs_d;
            dmem_q     <= dmem_d;
        end
    end

    // Instruction memory write port; contents beyond count are never fetched
    always_ff @(posedge clk_i) begin
        if (imem_we) imem_q[imem_waddr] <= imem_wdata;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_i == LOAD_MARKER) state_d = ST_LOAD;
            ST_LOAD: if (byte_idx_q == 2'd0 && instr_i == END_MARKER) state_d = ST_RUN;
            ST_RUN:  if (at_end || !valid) state_d = ST_HALT;
            ST_HALT: if (instr_i == LOAD_MARKER) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: byte assembly during LOAD, execute/writeback during RUN
    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        regs_d     = regs_q;
        dmem_d     = dmem_q;
        imem_we    = 1'b0;
        imem_waddr = count_q[5:0];
        imem_wdata = {instr_i, word_buf_q};
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (instr_i == LOAD_MARKER) begin
                    byte_idx_d = 2'd0;
                    count_d    = 7'd0;
                end
            end
            ST_LOAD: begin
                if (byte_idx_q == 2'd0 && instr_i == END_MARKER) begin
                    pc_d = 6'd0;
                end else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_buf_d[7:0]   = instr_i;
                        2'd1: word_buf_d[15:8]  = instr_i;
                        2'd2: word_buf_d[23:16] = instr_i;
                        default: begin
                            // Words past the end of imem are silently dropped
                            if (count_q < 7'(IMEM_WORDS)) begin
                                imem_we = 1'b1;
                                count_d = count_q + 7'd1;
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (!at_end && valid) begin
                    if (wb_alu && rd != 5'd0)  regs_d[rd] = alu_y;
                    if (wb_load && rd != 5'd0) regs_d[rd] = dmem_q[mem_addr];
                    if (do_store)              dmem_d[mem_addr] = rs2_val;
                    pc_d = (do_branch && br_taken) ? pc_q + br_off : pc_q + 6'd1;
                end
            end
            default: ;
        endcase
    end

    // Status output: one-hot {halted, running, loading}
    always_comb begin
        easter_egg = 3'b000;
        case (state_q)
            ST_LOAD: easter_egg = 3'b001;
            ST_RUN:  easter_egg = 3'b010;
            ST_HALT: easter_egg = 3'b100;
            default: easter_egg = 3'b000;
        endcase
    end

    logic [31:0] dbg_word;

    // Debug read: pick a register or data word, then one byte lane
    always_comb begin
        dbg_word = DataOrReg ? regs_q[address] : dmem_q[address];
        case (vout_addr)
            2'd0:    value_o = dbg_word[7:0];
            2'd1:    value_o = dbg_word[15:8];
            2'd2:    value_o = dbg_word[23:16];
            default: value_o = dbg_word[31:24];
        endcase
    end

    assign is_positive = !value_o[7] && (value_o != 8'h00);

endmodule

// File: tb/tb_lane_simd_cpu.sv
// Directed bench for lane_simd_cpu: programs are streamed byte-serially,
// results read back through the debug port after each halt.
module tb_lane_simd_cpu;

    logic       clk_i = 1'b0;
    logic       reset;
    logic [7:0] instr_i;
    logic       DataOrReg;
    logic [4:0] address;
    logic [1:0] vout_addr;
    logic [7:0] value_o;
    logic       is_positive;
    logic [2:0] easter_egg;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] prog [$];

    lane_simd_cpu dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .instr_i     (instr_i),
        .DataOrReg   (DataOrReg),
        .address     (address),
        .vout_addr   (vout_addr),
        .value_o     (value_o),
        .is_positive (is_positive),
        .easter_egg  (easter_egg)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_i);
        instr_i = b;
    endtask

    task automatic send_prog();
        send_byte(8'hFE);
        @(posedge clk_i);
        #1;
        check("state_load", {29'b0, easter_egg}, 32'h1);
        foreach (prog[i]) begin
            for (int k = 0; k < 4; k++) send_byte(prog[i][8*k +: 8]);
        end
        send_byte(8'hFF);
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        @(negedge clk_i);
        instr_i = 8'h00;
        while (easter_egg != 3'b100 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, {29'b0, easter_egg}, 32'h4);
    endtask

    task automatic rd_word(input logic sel, input logic [4:0] a, output logic [31:0] w);
        DataOrReg = sel;
        address   = a;
        for (int l = 0; l < 4; l++) begin
            vout_addr = 2'(l);
            #1;
            w[8*l +: 8] = value_o;
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        logic [31:0] w;
        rd_word(1'b1, r, w);
        check(tag, w, exp);
    endtask

    task automatic check_mem(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] w;
        rd_word(1'b0, a, w);
        check(tag, w, exp);
    endtask

    task automatic check_pos(input string tag, input logic sel, input logic [4:0] a,
                             input logic [1:0] lane, input logic exp);
        DataOrReg = sel;
        address   = a;
        vout_addr = lane;
        #1;
        check(tag, {31'b0, is_positive}, {31'b0, exp});
    endtask

    // Directed sequence
    initial begin
        reset     = 1'b0;
        instr_i   = 8'h00;
        DataOrReg = 1'b1;
        address   = 5'd5;
        vout_addr = 2'd2;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_value", {24'b0, value_o}, 32'h0);
        check("rst_pos", {31'b0, is_positive}, 32'h0);
        check("rst_state", {29'b0, easter_egg}, 32'h0);
        @(negedge clk_i);
        reset = 1'b1;
        repeat (2) @(negedge clk_i);
        check("idle_state", {29'b0, easter_egg}, 32'h0);

        // Immediates
        prog = {};
        prog.push_back(enc_i(12'd5, 5'd0, 3'd0, 5'd1));
        prog.push_back(enc_i(12'hFFC, 5'd0, 3'd0, 5'd2));
        send_prog();
        wait_halt("halt_a");
        check_reg("addi_5", 5'd1, 32'h05050505);
        check_reg("addi_m4", 5'd2, 32'hFCFCFCFC);
        check_pos("pos_x1", 1'b1, 5'd1, 2'd1, 1'b1);
        check_pos("pos_x2", 1'b1, 5'd2, 2'd0, 1'b0);

        // Register-register lane ops, wrap-around and x0 discard
        prog = {};
        prog.push_back(enc_i(12'd127, 5'd0, 3'd0, 5'd3));
        prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd4));
        prog.push_back(enc_r(7'h00, 5'd4, 5'd3, 3'd0, 5'd5));
        prog.push_back(enc_r(7'h20, 5'd3, 5'd4, 3'd0, 5'd6));
        prog.push_back(enc_r(7'h00, 5'd3, 5'd4, 3'd2, 5'd7));
        prog.push_back(enc_r(7'h00, 5'd4, 5'd3, 3'd2, 5'd8));
        prog.push_back(enc_r(7'h00, 5'd4, 5'd2, 3'd2, 5'd9));
        prog.push_back(enc_i(12'hF80, 5'd0, 3'd0, 5'd10));
        prog.push_back(enc_r(7'h00, 5'd10, 5'd10, 3'd0, 5'd11));
        prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd12));
        prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd13));
        prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd14));
        prog.push_back(enc_i(12'h00F, 5'd1, 3'd4, 5'd15));
        prog.push_back(enc_i(12'h030, 5'd1, 3'd6, 5'd16));
        prog.push_back(enc_i(12'h00F, 5'd2, 3'd7, 5'd17));
        prog.push_back(enc_i(12'd7, 5'd0, 3'd0, 5'd0));
        prog.push_back(enc_r(7'h00, 5'd1, 5'd3, 3'd0, 5'd18));
        send_prog();
        wait_halt("halt_b");
        check_reg("add_wrap", 5'd5, 32'h80808080);
        check_reg("sub", 5'd6, 32'h82828282);
        check_reg("slt_true", 5'd7, 32'h01010101);
        check_reg("slt_false", 5'd8, 32'h00000000);
        check_reg("slt_signed", 5'd9, 32'h01010101);
        check_reg("addi_m128", 5'd10, 32'h80808080);
        check_reg("add_nocarry", 5'd11, 32'h00000000);
        check_reg("xor", 5'd12, 32'hF9F9F9F9);
        check_reg("or", 5'd13, 32'hFDFDFDFD);
        check_reg("and", 5'd14, 32'h04040404);
        check_reg("xori", 5'd15, 32'h0A0A0A0A);
        check_reg("ori", 5'd16, 32'h35353535);
        check_reg("andi", 5'd17, 32'h0C0C0C0C);
        check_reg("x0_zero", 5'd0, 32'h00000000);
        check_reg("add_7f_05", 5'd18, 32'h84848484);

        // Loads and stores, address wrap modulo 32
        prog = {};
        prog.push_back(enc_sw(12'd8, 5'd1, 5'd0));
        prog.push_back(enc_lw(12'd8, 5'd0, 5'd19));
        prog.push_back(enc_sw(12'd35, 5'd2, 5'd0));
        prog.push_back(enc_lw(12'd3, 5'd0, 5'd20));
        prog.push_back(enc_lw(12'd2, 5'd4, 5'd21));
        send_prog();
        wait_halt("halt_c");
        for (int l = 3; l >= 0; l--) begin
            DataOrReg = 1'b0;
            address   = 5'd8;
            vout_addr = 2'(l);
            #1;
            check("dmem8_lane", {24'b0, value_o}, 32'h05);
        end
        check_reg("lw_x19", 5'd19, 32'h05050505);
        check_mem("sw_wrap", 5'd3, 32'hFCFCFCFC);
        check_reg("lw_x20", 5'd20, 32'hFCFCFCFC);
        check_reg("lw_rs1", 5'd21, 32'hFCFCFCFC);
        check_mem("dmem0", 5'd0, 32'h00000000);
        check_pos("pos_dmem3", 1'b0, 5'd3, 2'd3, 1'b0);

        // Branches taken and not taken
        prog = {};
        prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd22));
        prog.push_back(enc_b(13'd8, 5'd0, 5'd0, 3'd0));
        prog.push_back(enc_i(12'd9, 5'd0, 3'd0, 5'd23));
        prog.push_back(enc_b(13'd8, 5'd0, 5'd0, 3'd1));
        prog.push_back(enc_i(12'd3, 5'd0, 3'd0, 5'd24));
        prog.push_back(enc_b(13'd8, 5'd0, 5'd22, 3'd1));
        prog.push_back(enc_i(12'd6, 5'd0, 3'd0, 5'd25));
        prog.push_back(enc_i(12'd7, 5'd0, 3'd0, 5'd26));
        prog.push_back(enc_b(13'd8, 5'd0, 5'd22, 3'd0));
        prog.push_back(enc_i(12'd2, 5'd0, 3'd0, 5'd27));
        send_prog();
        wait_halt("halt_d");
        check_reg("beq_skip", 5'd23, 32'h00000000);
        check_reg("bne_fall", 5'd24, 32'h03030303);
        check_reg("bne_skip", 5'd25, 32'h00000000);
        check_reg("bne_target", 5'd26, 32'h07070707);
        check_reg("beq_fall", 5'd27, 32'h02020202);

        // Empty program halts at once and keeps state
        prog = {};
        send_prog();
        wait_halt("halt_empty");
        check_reg("keep_x1", 5'd1, 32'h05050505);

        // 0xFF as data at byte index 2, then an undefined opcode halts
        prog = {};
        prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd28));
        prog.push_back(enc_i(12'd15, 5'd31, 3'd0, 5'd30));
        prog.push_back(32'h00000000);
        prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd29));
        send_prog();
        wait_halt("halt_f");
        check_reg("pre_undef", 5'd28, 32'h01010101);
        check_reg("ff_as_data", 5'd30, 32'h0F0F0F0F);
        check_reg("post_undef", 5'd29, 32'h00000000);

        // Asynchronous reset during an endless loop
        prog = {};
        prog.push_back(enc_b(13'd0, 5'd0, 5'd0, 3'd0));
        send_prog();
        @(negedge clk_i);
        instr_i = 8'h00;
        repeat (3) @(negedge clk_i);
        check("run_state", {29'b0, easter_egg}, 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check("async_idle", {29'b0, easter_egg}, 32'h0);
        check_reg("async_x1", 5'd1, 32'h00000000);
        check_mem("async_dmem8", 5'd8, 32'h00000000);
        @(negedge clk_i);
        reset = 1'b1;
        repeat (2) @(negedge clk_i);
        check("post_rst_idle", {29'b0, easter_egg}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
